// File: rtl/col1_seq_driver_if.sv
// Handshake/bus bundle between the col1 sequence driver and its controller.
// COL1_SEQ_ERRLOG_EN adds the err_valid/err_step error-log signals.
interface col1_seq_driver_if;
    logic       start;
    logic [5:0] exp_l;
    logic       L_in;
    logic       D;
    logic       X;
    logic       A;
    logic [2:0] step;
    logic       busy;
    logic       done;
    logic [5:0] l_capt;
    logic       pass;
`ifdef COL1_SEQ_ERRLOG_EN
    logic       err_valid;
    logic [2:0] err_step;

    modport master (
        output start, exp_l, L_in,
        input  D, X, A, step, busy, done, l_capt, pass, err_valid, err_step
    );
    modport slave (
        input  start, exp_l, L_in,
        output D, X, A, step, busy, done, l_capt, pass, err_valid, err_step
    );
`else
    modport master (
        output start, exp_l, L_in,
        input  D, X, A, step, busy, done, l_capt, pass
    );
    modport slave (
        input  start, exp_l, L_in,
        output D, X, A, step, busy, done, l_capt, pass
    );
`endif
endinterface

// File: rtl/col1_seq_driver.sv
// On-chip self-test sequencer: walks col1 D/X/A through a fixed 6-step Gray-like
// sequence and checks the returned L. Optional error log: COL1_SEQ_ERRLOG_EN.
module col1_seq_driver #(
    parameter int unsigned HOLD_CYCLES = 20
) (
    input  logic              clk,
    input  logic              rst,
    col1_seq_driver_if.slave  bus
);
    localparam int unsigned      CW       = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0]    CNT_LAST = CW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t        state_r;
    logic [CW-1:0] cnt_r;
    logic [2:0]    step_r;
    logic [2:0]    dxa_r;
    logic          busy_r;
    logic          done_r;
    logic          pass_r;
    logic [5:0]    l_capt_r;
    logic [5:0]    exp_lat_r;
    logic [5:0]    capt_next_s;

    // {D,X,A} drive pattern for each step of the walk
    function automatic logic [2:0] dxa_of(input logic [2:0] s);
        logic [2:0] v;
        case (s)
            3'd0:    v = 3'b000;
            3'd1:    v = 3'b001;
            3'd2:    v = 3'b011;
            3'd3:    v = 3'b111;
            3'd4:    v = 3'b101;
            3'd5:    v = 3'b100;
            default: v = 3'b000;
        endcase
        return v;
    endfunction

    // Unsampled capture bits are 0, so OR-ing the new sample in is exact
    assign capt_next_s = l_capt_r | (6'(bus.L_in) << step_r);

`ifdef COL1_SEQ_ERRLOG_EN
    logic       err_valid_r;
    logic [2:0] err_step_r;
    logic       miss_s;

    assign miss_s        = |((capt_next_s ^ exp_lat_r) & (6'b000001 << step_r));
    assign bus.err_valid = err_valid_r;
    assign bus.err_step  = err_step_r;

    // First-mismatch error log, cleared on reset and on an accepted start
    always_ff @(posedge clk) begin
        if (rst) begin
            err_valid_r <= 1'b0;
            err_step_r  <= 3'd0;
        end else if (state_r == IDLE && bus.start) begin
            err_valid_r <= 1'b0;
            err_step_r  <= 3'd0;
        end else if (state_r == RUN && cnt_r == CNT_LAST && miss_s && !err_valid_r) begin
            err_valid_r <= 1'b1;
            err_step_r  <= step_r;
        end
    end
`endif

    // Walk sequencer: IDLE -> RUN (6 steps) -> FIN (done pulse) -> IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            step_r    <= 3'd0;
            dxa_r     <= 3'b000;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            pass_r    <= 1'b0;
            l_capt_r  <= 6'd0;
            exp_lat_r <= 6'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        exp_lat_r <= bus.exp_l;
                        l_capt_r  <= 6'd0;
                        pass_r    <= 1'b0;
                        step_r    <= 3'd0;
                        cnt_r     <= '0;
                        dxa_r     <= dxa_of(3'd0);
                        busy_r    <= 1'b1;
                        state_r   <= RUN;
                    end
                end
                RUN: begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_r    <= '0;
                        l_capt_r <= capt_next_s;
                        if (step_r == 3'd5) begin
                            // Done/pass are registered so they appear in FIN
                            state_r <= FIN;
                            done_r  <= 1'b1;
                            busy_r  <= 1'b0;
                            pass_r  <= (capt_next_s == exp_lat_r);
                            dxa_r   <= 3'b000;
                            step_r  <= 3'd0;
                        end else begin
                            step_r <= step_r + 3'd1;
                            dxa_r  <= dxa_of(step_r + 3'd1);
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                FIN: begin
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    dxa_r   <= 3'b000;
                    step_r  <= 3'd0;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

    assign bus.D      = dxa_r[2];
    assign bus.X      = dxa_r[1];
    assign bus.A      = dxa_r[0];
    assign bus.step   = step_r;
    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.l_capt = l_capt_r;
    assign bus.pass   = pass_r;
endmodule

// File: tb/tb_col1_seq_driver.sv
// Scoreboard bench for col1_seq_driver: HOLD_CYCLES=4 and HOLD_CYCLES=1 instances
// driven with directed and random walks against a time-based reference model.
module tb_col1_seq_driver;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    col1_seq_driver_if if_a ();
    col1_seq_driver_if if_b ();

    col1_seq_driver #(.HOLD_CYCLES(4)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
    col1_seq_driver #(.HOLD_CYCLES(1)) dut_b (.clk(clk), .rst(rst), .bus(if_b));

    logic       start_v [2];
    logic [5:0] exp_v   [2];
    logic       lin_v   [2];
    int         hold_v  [2];

    logic [2:0] dxa_o  [2];
    logic [2:0] step_o [2];
    logic       busy_o [2];
    logic       done_o [2];
    logic       pass_o [2];
    logic [5:0] capt_o [2];

    assign if_a.start = start_v[0];
    assign if_a.exp_l = exp_v[0];
    assign if_a.L_in  = lin_v[0];
    assign if_b.start = start_v[1];
    assign if_b.exp_l = exp_v[1];
    assign if_b.L_in  = lin_v[1];

    assign dxa_o[0]  = {if_a.D, if_a.X, if_a.A};
    assign step_o[0] = if_a.step;
    assign busy_o[0] = if_a.busy;
    assign done_o[0] = if_a.done;
    assign pass_o[0] = if_a.pass;
    assign capt_o[0] = if_a.l_capt;
    assign dxa_o[1]  = {if_b.D, if_b.X, if_b.A};
    assign step_o[1] = if_b.step;
    assign busy_o[1] = if_b.busy;
    assign done_o[1] = if_b.done;
    assign pass_o[1] = if_b.pass;
    assign capt_o[1] = if_b.l_capt;

`ifdef COL1_SEQ_ERRLOG_EN
    logic       errv_o [2];
    logic [2:0] errs_o [2];
    assign errv_o[0] = if_a.err_valid;
    assign errs_o[0] = if_a.err_step;
    assign errv_o[1] = if_b.err_valid;
    assign errs_o[1] = if_b.err_step;
`endif

    // The walk as the specification lists it, {D,X,A}
    logic [2:0] walk_tbl [6];
    initial begin
        walk_tbl[0] = 3'b000; walk_tbl[1] = 3'b001; walk_tbl[2] = 3'b011;
        walk_tbl[3] = 3'b111; walk_tbl[4] = 3'b101; walk_tbl[5] = 3'b100;
    end

    int checks = 0;
    int errors = 0;
    logic [6:0] exp_q0 [$];
    logic [6:0] exp_q1 [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse pops the expected {pass, l_capt} for that DUT
    always @(negedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (done_o[s] === 1'b1) begin
                logic [6:0] e;
                int qsz;
                qsz = (s == 0) ? exp_q0.size() : exp_q1.size();
                if (qsz == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done dut%0d: got done=1 expected no done", s);
                end else begin
                    if (s == 0) e = exp_q0.pop_front();
                    else        e = exp_q1.pop_front();
                    chk($sformatf("done_result dut%0d", s), {25'd0, pass_o[s], capt_o[s]}, {25'd0, e});
                    chk($sformatf("done_idle dut%0d", s), {24'd0, busy_o[s], dxa_o[s], step_o[s]}, 32'd0);
                end
            end
        end
    end

    task automatic run_walk(input int s, input logic [5:0] pat, input logic [5:0] exp, input bit poke);
        int h;
        int n;
        int lo;
        logic [5:0] mask;
        h = hold_v[s];
        @(posedge clk); #1;
        start_v[s] = 1'b1;
        exp_v[s]   = exp;
        lin_v[s]   = pat[0];
        if (s == 0) exp_q0.push_back({(pat == exp), pat});
        else        exp_q1.push_back({(pat == exp), pat});
        for (int k = 1; k <= 6 * h; k++) begin
            @(posedge clk); #1;
            n = (k - 1) / h;
            start_v[s] = poke && (k == 5 || k == 6 * h);
            exp_v[s]   = 6'($urandom);
            lin_v[s]   = pat[n];
            mask       = 6'((1 << n) - 1);
            chk($sformatf("walk_dxa dut%0d k%0d", s, k), {29'd0, dxa_o[s]}, {29'd0, walk_tbl[n]});
            chk($sformatf("walk_step dut%0d k%0d", s, k), {29'd0, step_o[s]}, n);
            chk($sformatf("walk_flags dut%0d k%0d", s, k), {29'd0, busy_o[s], done_o[s], pass_o[s]}, 32'd4);
            chk($sformatf("walk_capt dut%0d k%0d", s, k), {26'd0, capt_o[s]}, {26'd0, pat & mask});
        end
        @(posedge clk); #1;
        start_v[s] = 1'b0;
        lin_v[s]   = 1'($urandom);
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk($sformatf("done_seen dut%0d", s), (s == 0) ? exp_q0.size() : exp_q1.size(), 32'd0);
        chk($sformatf("hold_result dut%0d", s), {25'd0, pass_o[s], capt_o[s]}, {25'd0, (pat == exp), pat});
        chk($sformatf("hold_idle dut%0d", s), {25'd0, busy_o[s], dxa_o[s], step_o[s]}, 32'd0);
`ifdef COL1_SEQ_ERRLOG_EN
        lo = 0;
        for (int i = 5; i >= 0; i--) if (pat[i] != exp[i]) lo = i;
        chk($sformatf("err_valid dut%0d", s), {31'd0, errv_o[s]}, {31'd0, (pat != exp)});
        if (pat != exp) chk($sformatf("err_step dut%0d", s), {29'd0, errs_o[s]}, lo);
`else
        lo = 0;
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] pat;
        logic [5:0] ex;
        int s;
        hold_v[0] = 4; hold_v[1] = 1;
        for (int i = 0; i < 2; i++) begin
            start_v[i] = 1'b0; exp_v[i] = 6'd0; lin_v[i] = 1'b0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Idle after reset with no start
        repeat (20) begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++)
                chk($sformatf("reset_idle dut%0d", i),
                    {18'd0, dxa_o[i], step_o[i], busy_o[i], done_o[i], capt_o[i], pass_o[i]}, 32'd0);
        end

        run_walk(0, 6'b011110, 6'b011110, 1'b0);
        run_walk(0, 6'b011110, 6'b111110, 1'b0);
        run_walk(0, 6'b011110, 6'b011110, 1'b1);

        // Reset mid-walk: outputs clear, no done pulse
        @(posedge clk); #1;
        start_v[0] = 1'b1; exp_v[0] = 6'b011110; lin_v[0] = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            start_v[0] = 1'b0;
        end
        chk("abort_pre_capt", {26'd0, capt_o[0]}, 32'd3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_clear", {18'd0, dxa_o[0], step_o[0], busy_o[0], done_o[0], capt_o[0], pass_o[0]}, 32'd0);
        repeat (3) @(posedge clk);
        run_walk(0, 6'b101010, 6'b101010, 1'b0);

        run_walk(1, 6'b111111, 6'b111111, 1'b0);

        for (int i = 0; i < 10; i++) begin
            s   = $urandom_range(0, 1);
            pat = 6'($urandom);
            ex  = ($urandom_range(0, 1) == 0) ? pat : (pat ^ 6'($urandom_range(1, 63)));
            run_walk(s, pat, ex, 1'($urandom_range(0, 1)));
        end

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
